// File: rtl/dut_drv_pkg.sv
// Shared types for the DUT transaction driver: command record, opcode, FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dut_drv_pkg;

  localparam int CMD_ADDR_W = 3;
  localparam int CMD_DATA_W = 1;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } drv_state_e;

endpackage

// File: rtl/drv_cmd_fifo.sv
// In-order command buffer between the command stream and the issue FSM.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push ignored while full (no same-cycle pop bypass); pop ignored while empty.
// Ports: clk/reset (sync, active-high); push/push_cmd write side; pop/head read side;
//        full/empty derived from read/write pointers carrying one extra wrap bit.
module drv_cmd_fifo
  import dut_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only observed between valid pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

endmodule

// File: rtl/dut_txn_driver.sv
// Buffers write/read commands and issues them in order to the DUT en/rdy method ports.
// Latency: command pushed in cycle N issues no earlier than N+2; read result registered one cycle after issue.
// Backpressure: cmd_ready drops when the FIFO is full; reads stall while a response is unconsumed.
// Ports: clk, reset (sync, active-high); cmd_* command stream; resp_* read response stream;
//        write_* / read_* DUT method ports; busy = work pending.
// Optional macro DRV_STATS_EN adds wr_count/rd_count fire counters (CNT_W bits, wrapping).
module dut_txn_driver
  import dut_drv_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              busy
`ifdef DRV_STATS_EN
  ,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  drv_state_e state;
  drv_state_e state_nxt;
  cmd_t       cur;
  cmd_t       head;
  cmd_t       push_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign cmd_ready = !fifo_full && !reset;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    push_cmd      = '0;
    push_cmd.op   = op_e'(cmd_op);
    push_cmd.addr = cmd_addr;
    push_cmd.data = cmd_data;
  end

  drv_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = (head.op == OP_WRITE) ? WRITE : READ;
        end
      end
      WRITE: begin
        write_en = write_rdy && !reset;
        if (write_en) state_nxt = IDLE;
      end
      READ: begin
        // Holding off until the response register is free keeps responses
        // lossless and means capture and consume never coincide.
        read_en = read_rdy && !resp_valid && !reset;
        if (read_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cur <= head;
    end
  end

  assign write_address = cur.addr;
  assign write_data    = cur.data;
  assign read_address  = cur.addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_data  <= '0;
    end else if (read_en) begin
      resp_valid <= 1'b1;
      resp_addr  <= cur.addr;
      resp_data  <= read_data;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign busy = !fifo_empty || (state != IDLE);

`ifdef DRV_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (write_en) wr_count <= wr_count + 1'b1;
      if (read_en)  rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule
